tp_mem_arb: RTL and testbench
=============================

# tp_mem_arb

Shared-access controller for the 512x16 two-port activation/weight scratch memory. It zero-initialises the memory after reset or on command, then arbitrates NREQ read requesters onto the single read port and NREQ write requesters onto the single write port, each with a round-robin policy. It resolves same-address read/write collisions and returns read data tagged with a one-hot valid to the granted requester. It sits between the MVU-side clients and the banked SRAM wrapper. The SRAM read latency is 1 cycle.

## Interface
- NREQ, 2, number of read requesters and of write requesters (2..8)
- AW, 9, memory address width (depth 2^AW = 512)
- DW, 16, data width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- init_start  in  1  pulse; starts zero-fill when in RUN
- init_busy  out  1  high in IDLE and INIT
- rd_req  in  NREQ  per-requester read request
- rd_addr  in  NREQ*AW  packed read addresses, requester i at [i*AW +: AW]
- rd_gnt  out  NREQ  one-hot read grant (combinational)
- rd_vld  out  NREQ  one-hot, registered; rd_data valid for that requester
- rd_data  out  DW  read data, equals mem_rd_word
- wr_req  in  NREQ  per-requester write request
- wr_addr  in  NREQ*AW  packed write addresses
- wr_data  in  NREQ*DW  packed write data
- wr_gnt  out  NREQ  one-hot write grant (combinational); write commits this cycle
- mem_rd_en, mem_rd_addr  out  1, AW  SRAM read port
- mem_rd_word  in  DW  SRAM read data, 1 cycle after mem_rd_en
- mem_wr_en, mem_wr_addr, mem_wr_word  out  1, AW, DW  SRAM write port

## Operation
- FSM states IDLE, INIT, RUN. Reset state is IDLE.
- IDLE goes to INIT on the next clock, unconditionally.
- INIT: init counter runs 0..511. Each cycle drives mem_wr_en=1, mem_wr_addr=counter, mem_wr_word=0. After counter 511 the FSM goes to RUN and the counter resets to 0.
- RUN with init_start=1 goes to INIT next cycle. init_start is ignored in IDLE and INIT.
- In IDLE and INIT: all rd_gnt and wr_gnt are 0, and mem_rd_en is 0.
- RUN, write port:
  - Round-robin over wr_req starting at wr_ptr.
  - The winner's addr/data drive the mem write port with mem_wr_en=1.
  - wr_ptr becomes winner+1 (mod NREQ) on that clock.
- RUN, read port:
  - Round-robin over rd_req starting at rd_ptr. Candidate winner w.
  - Collision rule: if a write is granted this cycle and rd_addr[w]==mem_wr_addr, the read grant is withheld. rd_gnt=0, mem_rd_en=0, rd_ptr unchanged. The write proceeds.
  - Otherwise rd_gnt[w]=1, mem_rd_en=1, and rd_ptr becomes w+1.
- Requesters keep req and address stable until granted. Deasserting req before grant is legal and simply drops out of arbitration.
- rd_vld is rd_gnt registered by one cycle. rd_data is mem_rd_word passed through.

## Timing
- While rst_n=0: state=IDLE, pointers=0, counter=0, rd_vld=0. All combinational outputs evaluate to 0 except init_busy=1.
- After reset release: edge 1 enters INIT (write addr 0); addresses 0..511 are written on edges 1..512; edge 513 enters RUN.
- Read: grant in cycle N; rd_vld and rd_data in cycle N+1.
- A stalled colliding read is granted at the earliest in N+1 and sees the newly written data.
- init_start in RUN while a read is in flight: that rd_vld still fires the following cycle. No new grants are issued once INIT is entered.
- rst_n asserted mid-INIT or mid-RUN: immediate return to IDLE, rd_vld cleared, and the fill restarts from address 0 after release.
- All requests on one port asserted every cycle: each requester is granted once per NREQ cycles. No starvation beyond NREQ-1 cycles, except while collision stalls are active.

## Structure
- Package tp_mem_pkg holds:
  - MEM_AW=9, MEM_DW=16, MEM_DEPTH=512
  - the state enum {IDLE, INIT, RUN}
- Sub-module rr_arb (parameter N) takes req, ptr and an enable, and returns a one-hot grant plus the encoded winner index. It is instantiated twice (read, write).
- Pointer registers, the FSM, the init counter and rd_vld stay in tp_mem_arb.

## Test plan
- Reset release:
  - init_busy stays 1 for 513 cycles.
  - mem_wr_en=1 with addresses 0..511 and data 0.
  - Then RUN, and a read of addr 300 returns 0x0000.
- Write/read ordering:
  - Requester 1 writes 0xBEEF to addr 17.
  - Requester 0 reads addr 17 two cycles later, then rd_vld=2'b01 and rd_data=0xBEEF one cycle after rd_gnt.
- Round-robin fairness:
  - Both rd_req held high for 8 cycles, so grants alternate 01,10,01,...
  - Same check on wr_gnt.
- Collision:
  - In the same cycle, write 0x1234 to addr 5 and read addr 5.
  - Then rd_gnt=0 in that cycle, the read is granted next cycle, and rd_data=0x1234.
- Re-init:
  - Fill addr 0..3 with nonzero data, pulse init_start.
  - Grants are 0 for 512 cycles, then reads of 0..3 return 0.
- Reset mid-INIT:
  - Assert rst_n=0 at counter 200, then release.
  - The fill restarts at address 0 and RUN is reached 513 cycles after release.

Source files
------------

// File: rtl/tp_mem_pkg.sv
// Shared constants and FSM state type for the scratch-memory access controller.
package tp_mem_pkg;

  localparam int MEM_AW    = 9;
  localparam int MEM_DW    = 16;
  localparam int MEM_DEPTH = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } tp_state_e;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: scans req starting at ptr and returns a one-hot grant
// plus the encoded winner index. Nothing is granted while en is low.
module rr_arb #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (en && !any && req[cand[IW-1:0]]) begin
        any                = 1'b1;
        idx                = cand[IW-1:0];
        gnt[cand[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tp_mem_arb.sv
// Zero-fills the 2-port scratch memory, then round-robin arbitrates read and
// write requesters onto the single read and write ports.
module tp_mem_arb
  import tp_mem_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = MEM_AW,
  parameter int DW   = MEM_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_start,
  output logic               init_busy,
  input  logic [NREQ-1:0]    rd_req,
  input  logic [NREQ*AW-1:0] rd_addr,
  output logic [NREQ-1:0]    rd_gnt,
  output logic [NREQ-1:0]    rd_vld,
  output logic [DW-1:0]      rd_data,
  input  logic [NREQ-1:0]    wr_req,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  output logic [NREQ-1:0]    wr_gnt,
  output logic               mem_rd_en,
  output logic [AW-1:0]      mem_rd_addr,
  input  logic [DW-1:0]      mem_rd_word,
  output logic               mem_wr_en,
  output logic [AW-1:0]      mem_wr_addr,
  output logic [DW-1:0]      mem_wr_word,
  output logic [1:0]         dbg_state
);

  localparam int IW = $clog2(NREQ);

  tp_state_e       state_q, state_d;
  logic [AW-1:0]   cnt_q;
  logic [IW-1:0]   rd_ptr_q, wr_ptr_q, rd_idx, wr_idx;
  logic [NREQ-1:0] rd_cand, rd_vld_q;
  logic            rd_any, wr_any, run, collide;
  logic [AW-1:0]   rd_sel_addr, wr_sel_addr;
  logic [DW-1:0]   wr_sel_data;

  assign run       = (state_q == RUN);
  assign dbg_state = state_q;

  rr_arb #(.N(NREQ)) u_rd_arb (
    .req (rd_req),
    .ptr (rd_ptr_q),
    .en  (run),
    .gnt (rd_cand),
    .idx (rd_idx),
    .any (rd_any)
  );

  rr_arb #(.N(NREQ)) u_wr_arb (
    .req (wr_req),
    .ptr (wr_ptr_q),
    .en  (run),
    .gnt (wr_gnt),
    .idx (wr_idx),
    .any (wr_any)
  );

  assign rd_sel_addr = rd_addr[rd_idx*AW +: AW];
  assign wr_sel_addr = wr_addr[wr_idx*AW +: AW];
  assign wr_sel_data = wr_data[wr_idx*DW +: DW];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = INIT;
      INIT:    if (cnt_q == '1) state_d = RUN;
      RUN:     if (init_start) state_d = INIT;
      default: state_d = IDLE;
    endcase
  end

  // A read that would hit the address being written this cycle is held off
  // one cycle so it returns the new data; the write always goes ahead.
  always_comb begin
    init_busy   = !run;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_word = '0;
    if (state_q == INIT) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = cnt_q;
    end else if (wr_any) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = wr_sel_addr;
      mem_wr_word = wr_sel_data;
    end
    collide     = wr_any && rd_any && (rd_sel_addr == wr_sel_addr);
    rd_gnt      = collide ? '0 : rd_cand;
    mem_rd_en   = rd_any && !collide;
    mem_rd_addr = mem_rd_en ? rd_sel_addr : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_vld_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= (state_q == INIT) ? cnt_q + 1'b1 : '0;
      rd_vld_q <= rd_gnt;
      if (mem_rd_en)
        rd_ptr_q <= (rd_idx == IW'(NREQ-1)) ? '0 : rd_idx + 1'b1;
      if (wr_any)
        wr_ptr_q <= (wr_idx == IW'(NREQ-1)) ? '0 : wr_idx + 1'b1;
    end
  end

  assign rd_vld  = rd_vld_q;
  assign rd_data = mem_rd_word;

endmodule

// File: tb/tb_tp_mem_arb.sv
// Directed bench for tp_mem_arb with a 1-cycle-latency SRAM model.
module tb_tp_mem_arb;
  import tp_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_start;
  logic        init_busy;
  logic [1:0]  rd_req, rd_gnt, rd_vld, wr_req, wr_gnt;
  logic [17:0] rd_addr, wr_addr;
  logic [31:0] wr_data;
  logic [15:0] rd_data;
  logic        mem_rd_en, mem_wr_en;
  logic [8:0]  mem_rd_addr, mem_wr_addr;
  logic [15:0] mem_rd_word = 16'h0;
  logic [15:0] mem_wr_word;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tp_mem_arb #(.NREQ(2), .AW(9), .DW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_start  (init_start),
    .init_busy   (init_busy),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .rd_vld      (rd_vld),
    .rd_data     (rd_data),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_gnt      (wr_gnt),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_word (mem_rd_word),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_word (mem_wr_word),
    .dbg_state   (dbg_state)
  );

  // SRAM model, pre-loaded with garbage so the zero-fill is observable
  logic [15:0] mem [512] = '{default: 16'hA5A5};
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_word;
    if (mem_rd_en) mem_rd_word <= mem[mem_rd_addr];
  end

  typedef struct {
    logic [1:0]  rq;
    logic [8:0]  ra0, ra1;
    logic [1:0]  wq;
    logic [8:0]  wa0, wa1;
    logic [15:0] wd0, wd1;
    logic [1:0]  erg, ewg, evld;
    logic [15:0] edata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] rq, logic [8:0] ra0, logic [8:0] ra1,
                              logic [1:0] wq, logic [8:0] wa0, logic [8:0] wa1,
                              logic [15:0] wd0, logic [15:0] wd1,
                              logic [1:0] erg, logic [1:0] ewg, logic [1:0] evld,
                              logic [15:0] edata);
    vec_t v;
    v.rq = rq;   v.ra0 = ra0; v.ra1 = ra1;
    v.wq = wq;   v.wa0 = wa0; v.wa1 = wa1;
    v.wd0 = wd0; v.wd1 = wd1;
    v.erg = erg; v.ewg = ewg; v.evld = evld; v.edata = edata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_req = '0; wr_req = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
  endtask

  // Follows a fill that begins at the next edge; leaves time at RUN edge + 2.
  task automatic fill_check(input string tag);
    int bad;
    bad = 0;
    rd_req = 2'b11; wr_req = 2'b11;
    rd_addr = {9'd7, 9'd3}; wr_addr = {9'd9, 9'd8}; wr_data = 32'hFFFF_FFFF;
    for (int k = 1; k <= 512; k++) begin
      @(posedge clk); #2;
      if (!(dbg_state == INIT && init_busy && mem_wr_en && mem_wr_addr == 9'(k-1) &&
            mem_wr_word == 16'h0 && rd_gnt == 2'b00 && wr_gnt == 2'b00 && !mem_rd_en))
        bad++;
      if (k == 512) idle_inputs();
    end
    check({tag, " fill_bad_cycles"}, bad, 0);
    @(posedge clk); #2;
    check({tag, " state_run"}, dbg_state, RUN);
    check({tag, " init_busy_low"}, init_busy, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int i);
    rd_req = v.rq; rd_addr = {v.ra1, v.ra0};
    wr_req = v.wq; wr_addr = {v.wa1, v.wa0}; wr_data = {v.wd1, v.wd0};
    #3;
    check($sformatf("v%0d rd_gnt", i), rd_gnt, v.erg);
    check($sformatf("v%0d wr_gnt", i), wr_gnt, v.ewg);
    check($sformatf("v%0d rd_vld", i), rd_vld, v.evld);
    check($sformatf("v%0d mem_rd_en", i), mem_rd_en, |v.erg);
    check($sformatf("v%0d mem_wr_en", i), mem_wr_en, |v.ewg);
    if (v.evld != 2'b00)
      check($sformatf("v%0d rd_data", i), rd_data, v.edata);
    if (v.ewg != 2'b00) begin
      check($sformatf("v%0d mem_wr_addr", i), mem_wr_addr, v.ewg[1] ? v.wa1 : v.wa0);
      check($sformatf("v%0d mem_wr_word", i), mem_wr_word, v.ewg[1] ? v.wd1 : v.wd0);
    end
    if (v.erg != 2'b00)
      check($sformatf("v%0d mem_rd_addr", i), mem_rd_addr, v.erg[1] ? v.ra1 : v.ra0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    // read addr 300, then write 0xBEEF@17 by requester 1, read it back
    vecs.push_back(mk(2'b01, 9'd300, 9'd0, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b01, 2'b00, 2'b00, 16'h0));
    vecs.push_back(mk(2'b00, 9'd0, 9'd0, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b00, 2'b00, 2'b01, 16'h0000));
    vecs.push_back(mk(2'b00, 9'd0, 9'd0, 2'b10, 9'd0, 9'd17, 16'h0, 16'hBEEF, 2'b00, 2'b10, 2'b00, 16'h0));
    vecs.push_back(mk(2'b00, 9'd0, 9'd0, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00, 16'h0));
    vecs.push_back(mk(2'b01, 9'd17, 9'd0, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b01, 2'b00, 2'b00, 16'h0));
    vecs.push_back(mk(2'b00, 9'd0, 9'd0, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b00, 2'b00, 2'b01, 16'hBEEF));
    // both readers saturated; rd_ptr is 1 here so requester 1 goes first
    vecs.push_back(mk(2'b11, 9'd17, 9'd300, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b10, 2'b00, 2'b00, 16'h0));
    vecs.push_back(mk(2'b11, 9'd17, 9'd300, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b01, 2'b00, 2'b10, 16'h0000));
    vecs.push_back(mk(2'b11, 9'd17, 9'd300, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b10, 2'b00, 2'b01, 16'hBEEF));
    vecs.push_back(mk(2'b11, 9'd17, 9'd300, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b01, 2'b00, 2'b10, 16'h0000));
    vecs.push_back(mk(2'b11, 9'd17, 9'd300, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b10, 2'b00, 2'b01, 16'hBEEF));
    vecs.push_back(mk(2'b11, 9'd17, 9'd300, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b01, 2'b00, 2'b10, 16'h0000));
    vecs.push_back(mk(2'b11, 9'd17, 9'd300, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b10, 2'b00, 2'b01, 16'hBEEF));
    vecs.push_back(mk(2'b11, 9'd17, 9'd300, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b01, 2'b00, 2'b10, 16'h0000));
    vecs.push_back(mk(2'b00, 9'd0, 9'd0, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b00, 2'b00, 2'b01, 16'hBEEF));
    // both writers saturated; wr_ptr is 0 here
    for (int j = 0; j < 8; j++)
      vecs.push_back(mk(2'b00, 9'd0, 9'd0, 2'b11, 9'd40, 9'd41, 16'h1111, 16'h2222,
                        2'b00, (j % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 16'h0));
    // same-address collision: read held one cycle, then returns new data
    vecs.push_back(mk(2'b01, 9'd5, 9'd0, 2'b01, 9'd5, 9'd0, 16'h1234, 16'h0, 2'b00, 2'b01, 2'b00, 16'h0));
    vecs.push_back(mk(2'b01, 9'd5, 9'd0, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b01, 2'b00, 2'b00, 16'h0));
    vecs.push_back(mk(2'b00, 9'd0, 9'd0, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b00, 2'b00, 2'b01, 16'h1234));
    // concurrent read and write to different addresses both proceed
    vecs.push_back(mk(2'b10, 9'd0, 9'd41, 2'b10, 9'd0, 9'd6, 16'h0, 16'h5555, 2'b10, 2'b10, 2'b00, 16'h0));
    vecs.push_back(mk(2'b00, 9'd0, 9'd0, 2'b00, 9'd0, 9'd0, 16'h0, 16'h0, 2'b00, 2'b00, 2'b10, 16'h2222));

    // ---- reset ----
    rst_n = 1'b0; init_start = 1'b0;
    rd_req = 2'b11; wr_req = 2'b11; rd_addr = '0; wr_addr = '0; wr_data = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst state", dbg_state, IDLE);
    check("rst init_busy", init_busy, 1'b1);
    check("rst rd_gnt", rd_gnt, 2'b00);
    check("rst wr_gnt", wr_gnt, 2'b00);
    check("rst rd_vld", rd_vld, 2'b00);
    check("rst mem_rd_en", mem_rd_en, 1'b0);
    check("rst mem_wr_en", mem_wr_en, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("release state_idle", dbg_state, IDLE);
    fill_check("por");

    // ---- directed table in RUN ----
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // ---- re-init ----
    for (int i = 0; i < 4; i++) begin
      wr_req = 2'b01; wr_addr = {9'd0, 9'(i)}; wr_data = {16'h0, 16'(16'h100 + i)};
      #3;
      check($sformatf("prefill wr_gnt %0d", i), wr_gnt, 2'b01);
      @(posedge clk); #1;
    end
    idle_inputs();
    rd_req = 2'b01; rd_addr = {9'd0, 9'd1}; init_start = 1'b1;
    #3;
    check("reinit pulse rd_gnt", rd_gnt, 2'b01);
    @(posedge clk); #1;
    init_start = 1'b0;
    rd_req = 2'b11; wr_req = 2'b11; rd_addr = {9'd2, 9'd3}; wr_addr = {9'd2, 9'd3};
    #3;
    check("reinit state", dbg_state, INIT);
    check("reinit inflight rd_vld", rd_vld, 2'b01);
    check("reinit inflight rd_data", rd_data, 16'h0101);
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      if (rd_gnt != 2'b00 || wr_gnt != 2'b00 || mem_rd_en || mem_wr_addr != 9'(k)) bad++;
      if (k == 511) idle_inputs();
      @(posedge clk); #4;
    end
    check("reinit grant_block_cycles", bad, 0);
    check("reinit back_to_run", dbg_state, RUN);
    for (int i = 0; i < 4; i++) begin
      rd_req = 2'b01; rd_addr = {9'd0, 9'(i)};
      #1;
      check($sformatf("reinit read%0d rd_gnt", i), rd_gnt, 2'b01);
      @(posedge clk); #1;
      rd_req = 2'b00;
      #3;
      check($sformatf("reinit read%0d rd_vld", i), rd_vld, 2'b01);
      check($sformatf("reinit read%0d rd_data", i), rd_data, 16'h0000);
      @(posedge clk); #1;
    end

    // ---- reset mid-INIT at counter 200 ----
    init_start = 1'b1;
    @(posedge clk); #1;
    init_start = 1'b0;
    repeat (200) @(posedge clk);
    #3;
    check("midinit counter", mem_wr_addr, 9'd200);
    rst_n = 1'b0;
    #1;
    check("midinit rst state", dbg_state, IDLE);
    check("midinit rst init_busy", init_busy, 1'b1);
    check("midinit rst mem_wr_en", mem_wr_en, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill_check("midinit");

    // ---- reset mid-RUN with a read in flight ----
    rd_req = 2'b01; rd_addr = {9'd0, 9'd300};
    #2;
    check("midrun rd_gnt", rd_gnt, 2'b01);
    @(posedge clk); #1;
    idle_inputs();
    check("midrun rd_vld_before", rd_vld, 2'b01);
    rst_n = 1'b0;
    #1;
    check("midrun rst rd_vld", rd_vld, 2'b00);
    check("midrun rst state", dbg_state, IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
